// File: rtl/batch_capture.sv
// Capture buffer for the batch filter: records {in_ctrl, in_data} per stored sample,
// with skip/decimation, one-shot or ring (pre-stop history) modes, and a registered read port.
module batch_capture #(
   parameter int N       = 3,
   parameter int D_WIDTH = 32,
   parameter int DEPTH   = 1024,
   parameter int SKIP_W  = 16,
   parameter int DEC_W   = 8,
   localparam int AW     = $clog2(DEPTH)
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [N-1:0]         in_ctrl,
   input  logic [D_WIDTH-1:0]   in_data,
   input  logic                 in_valid,
   input  logic                 arm,
   input  logic                 ring,
   input  logic                 stop,
   input  logic [SKIP_W-1:0]    skip,
   input  logic [DEC_W-1:0]     decim,
   input  logic                 rd_en,
   input  logic [AW-1:0]        rd_addr,
   output logic [N+D_WIDTH-1:0] rd_data,
   output logic                 rd_valid,
   output logic                 busy,
   output logic                 done,
   output logic [AW:0]          count
);

   typedef enum logic [1:0] {S_IDLE, S_SKIP, S_CAPTURE, S_DONE} state_t;

   localparam logic [AW:0] FULL = {1'b1, {AW{1'b0}}};
   localparam logic [AW:0] LAST = {1'b0, {AW{1'b1}}};

   state_t                 r_state;
   logic                   r_ring;
   logic [SKIP_W-1:0]      r_skip_cnt;
   logic [DEC_W-1:0]       r_decim;
   logic [DEC_W-1:0]       r_phase;
   logic [AW-1:0]          r_wr_ptr;
   logic [AW:0]            r_count;
   logic                   r_busy;
   logic                   r_done;
   logic [N+D_WIDTH-1:0]   r_mem [DEPTH];
   logic [N+D_WIDTH-1:0]   r_rd_data;
   logic                   r_rd_valid;

   logic                   w_store;
   logic                   w_last;
   logic                   w_stop;
   logic [AW-1:0]          w_rd_phys;
   logic                   w_rd_in_range;

   always_comb begin
      w_store       = rst && (r_state == S_CAPTURE) && in_valid && (r_phase == '0);
      w_last        = w_store && !r_ring && (r_count == LAST);
      w_stop        = r_ring && stop;
      // Once a ring capture has wrapped, the write pointer sits on the oldest entry.
      w_rd_phys     = (!r_ring || (r_count != FULL)) ? rd_addr : (r_wr_ptr + rd_addr);
      w_rd_in_range = ({1'b0, rd_addr} < r_count);
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         r_state    <= S_IDLE;
         r_busy     <= 1'b0;
         r_done     <= 1'b0;
         r_ring     <= 1'b0;
         r_skip_cnt <= '0;
         r_decim    <= '0;
         r_phase    <= '0;
         r_wr_ptr   <= '0;
         r_count    <= '0;
      end else begin
         case (r_state)
            S_IDLE, S_DONE: begin
               if (arm) begin
                  r_ring     <= ring;
                  r_decim    <= decim;
                  r_skip_cnt <= skip;
                  r_phase    <= '0;
                  r_wr_ptr   <= '0;
                  r_count    <= '0;
                  r_busy     <= 1'b1;
                  r_done     <= 1'b0;
                  r_state    <= (skip != '0) ? S_SKIP : S_CAPTURE;
               end
            end
            S_SKIP: begin
               if (in_valid) begin
                  r_skip_cnt <= r_skip_cnt - 1'b1;
                  if (r_skip_cnt == SKIP_W'(1)) r_state <= S_CAPTURE;
               end
               if (w_stop) begin
                  r_state <= S_DONE;
                  r_busy  <= 1'b0;
                  r_done  <= 1'b1;
               end
            end
            S_CAPTURE: begin
               if (in_valid) r_phase <= (r_phase == r_decim) ? '0 : r_phase + 1'b1;
               if (w_store) begin
                  r_wr_ptr <= r_wr_ptr + 1'b1;
                  if (r_count != FULL) r_count <= r_count + 1'b1;
               end
               if (w_last || w_stop) begin
                  r_state <= S_DONE;
                  r_busy  <= 1'b0;
                  r_done  <= 1'b1;
               end
            end
            default: begin
               r_state <= S_IDLE;
               r_busy  <= 1'b0;
               r_done  <= 1'b0;
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (w_store) r_mem[r_wr_ptr] <= {in_ctrl, in_data};
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         r_rd_data  <= '0;
         r_rd_valid <= 1'b0;
      end else begin
         r_rd_valid <= rd_en;
         if (rd_en) r_rd_data <= w_rd_in_range ? r_mem[w_rd_phys] : '0;
      end
   end

   assign rd_data  = r_rd_data;
   assign rd_valid = r_rd_valid;
   assign busy     = r_busy;
   assign done     = r_done;
   assign count    = r_count;

endmodule

// File: tb/tb_batch_capture.sv
// Scoreboard bench for batch_capture at DEPTH=8: one-shot, skip/decimate, ring, arm handling, reset.
module tb_batch_capture;
   localparam int N = 3, DW = 32, DEPTH = 8, SW = 16, DECW = 8, AW = 3, RW = N + DW;

   logic            clk = 1'b0;
   logic            rst = 1'b0;
   logic [N-1:0]    in_ctrl = '0;
   logic [DW-1:0]   in_data = '0;
   logic            in_valid = 1'b0, arm = 1'b0, ring = 1'b0, stop = 1'b0, rd_en = 1'b0;
   logic [SW-1:0]   skip = '0;
   logic [DECW-1:0] decim = '0;
   logic [AW-1:0]   rd_addr = '0;
   logic [RW-1:0]   rd_data;
   logic            rd_valid, busy, done;
   logic [AW:0]     count;

   int            n_cmp = 0, n_bad = 0;
   logic [RW-1:0] sb[$];

   always #5 clk = ~clk;

   batch_capture #(.N(N), .D_WIDTH(DW), .DEPTH(DEPTH), .SKIP_W(SW), .DEC_W(DECW)) dut (
      .clk(clk), .rst(rst), .in_ctrl(in_ctrl), .in_data(in_data), .in_valid(in_valid),
      .arm(arm), .ring(ring), .stop(stop), .skip(skip), .decim(decim),
      .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data), .rd_valid(rd_valid),
      .busy(busy), .done(done), .count(count));

   always @(negedge clk) begin
      if (rst) begin
         n_cmp++;
         if (busy && done) begin
            n_bad++;
            $display("FAIL busy_done_exclusive: busy=%b done=%b required not both 1 at %0t", busy, done, $time);
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   function automatic logic [RW-1:0] ent(input int i);
      return {N'(i % 8), DW'(i)};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic sample(input int i, input bit v);
      in_ctrl  = N'(i % 8);
      in_data  = DW'(i);
      in_valid = v;
      tick();
      in_valid = 1'b0;
   endtask

   task automatic do_arm(input bit r, input int sk, input int dc);
      arm = 1'b1; ring = r; skip = SW'(sk); decim = DECW'(dc);
      tick();
      arm = 1'b0; ring = ~r; skip = '1; decim = '1;
   endtask

   task automatic issue_read(input int addr, input logic [RW-1:0] exp);
      rd_en   = 1'b1;
      rd_addr = AW'(addr);
      sb.push_back(exp);
   endtask

   task automatic test_reset();
      logic [RW-1:0] e;
      rst = 1'b0;
      tick(); tick();
      n_cmp++;
      if ({busy, done, rd_valid, count, rd_data} !== '0) begin
         n_bad++;
         $display("FAIL reset_state: busy=%b done=%b rd_valid=%b count=%0d rd_data=%h required all 0",
                  busy, done, rd_valid, count, rd_data);
      end
      rst = 1'b1;
      tick();
      issue_read(3, '0);
      tick();
      rd_en = 1'b0;
      n_cmp++;
      e = sb.pop_front();
      if (rd_valid !== 1'b1 || rd_data !== e) begin
         n_bad++;
         $display("FAIL idle_read: rd_valid=%b rd_data=%h required 1/%h", rd_valid, rd_data, e);
      end
   endtask

   task automatic test_oneshot();
      logic [RW-1:0] e;
      do_arm(1'b0, 0, 0);
      n_cmp++;
      if ({busy, done, count} !== {1'b1, 1'b0, 4'd0}) begin
         n_bad++;
         $display("FAIL oneshot_arm: busy=%b done=%b count=%0d required 1/0/0", busy, done, count);
      end
      for (int i = 0; i < 8; i++) begin
         sample(i, 1'b1);
         n_cmp++;
         if (done !== (i == 7) || busy !== (i != 7) || count !== 4'(i + 1)) begin
            n_bad++;
            $display("FAIL oneshot_store%0d: done=%b busy=%b count=%0d required %b/%b/%0d",
                     i, done, busy, count, i == 7, i != 7, i + 1);
         end
      end
      for (int i = 8; i < 12; i++) sample(i, 1'b1);
      n_cmp++;
      if (count !== 4'd8 || done !== 1'b1) begin
         n_bad++;
         $display("FAIL oneshot_hold: count=%0d done=%b required 8/1", count, done);
      end
      for (int a = 0; a < 8; a++) begin
         issue_read(a, ent(a));
         tick();
         n_cmp++;
         e = sb.pop_front();
         if (rd_valid !== 1'b1 || rd_data !== e) begin
            n_bad++;
            $display("FAIL oneshot_read%0d: rd_valid=%b rd_data=%h required 1/%h", a, rd_valid, rd_data, e);
         end
      end
      rd_en = 1'b0;
      tick();
      n_cmp++;
      if (rd_valid !== 1'b0 || sb.size() != 0) begin
         n_bad++;
         $display("FAIL read_pulse: rd_valid=%b pending=%0d required 0/0", rd_valid, sb.size());
      end
   endtask

   task automatic test_skip_decim();
      logic [RW-1:0] e;
      int nv = 0;
      do_arm(1'b0, 5, 2);
      while (done !== 1'b1 && nv < 60) begin
         sample(1000 + nv, 1'b0);
         sample(nv, 1'b1);
         nv++;
      end
      n_cmp++;
      if (nv != 27 || count !== 4'd8) begin
         n_bad++;
         $display("FAIL skip_decim_done: valid_samples=%0d count=%0d required 27/8", nv, count);
      end
      for (int a = 0; a < 8; a++) begin
         issue_read(a, ent(5 + 3 * a));
         tick();
         n_cmp++;
         e = sb.pop_front();
         if (rd_valid !== 1'b1 || rd_data !== e) begin
            n_bad++;
            $display("FAIL skip_decim_read%0d: rd_valid=%b rd_data=%h required 1/%h", a, rd_valid, rd_data, e);
         end
      end
      rd_en = 1'b0;
   endtask

   task automatic test_ring_full();
      logic [RW-1:0] e;
      do_arm(1'b1, 0, 0);
      for (int i = 0; i < 19; i++) sample(i, 1'b1);
      n_cmp++;
      if (done !== 1'b0 || busy !== 1'b1) begin
         n_bad++;
         $display("FAIL ring_no_autostop: done=%b busy=%b required 0/1", done, busy);
      end
      stop = 1'b1;
      sample(19, 1'b1);
      stop = 1'b0;
      n_cmp++;
      if (done !== 1'b1 || count !== 4'd8) begin
         n_bad++;
         $display("FAIL ring_stop: done=%b count=%0d required 1/8", done, count);
      end
      for (int a = 0; a < 8; a++) begin
         issue_read(a, ent(12 + a));
         tick();
         n_cmp++;
         e = sb.pop_front();
         if (rd_valid !== 1'b1 || rd_data !== e) begin
            n_bad++;
            $display("FAIL ring_read%0d: rd_valid=%b rd_data=%h required 1/%h", a, rd_valid, rd_data, e);
         end
      end
      rd_en = 1'b0;
   endtask

   task automatic test_ring_short();
      logic [RW-1:0] e;
      int addrs[5] = '{0, 1, 2, 3, 5};
      do_arm(1'b1, 0, 0);
      for (int i = 0; i < 3; i++) sample(i, 1'b1);
      stop = 1'b1;
      tick();
      stop = 1'b0;
      n_cmp++;
      if (done !== 1'b1 || count !== 4'd3) begin
         n_bad++;
         $display("FAIL ring_short_stop: done=%b count=%0d required 1/3", done, count);
      end
      foreach (addrs[k]) begin
         issue_read(addrs[k], (addrs[k] < 3) ? ent(addrs[k]) : '0);
         tick();
         n_cmp++;
         e = sb.pop_front();
         if (rd_valid !== 1'b1 || rd_data !== e) begin
            n_bad++;
            $display("FAIL ring_short_read%0d: rd_valid=%b rd_data=%h required 1/%h",
                     addrs[k], rd_valid, rd_data, e);
         end
      end
      rd_en = 1'b0;
   endtask

   task automatic test_arm_ignore();
      logic [RW-1:0] e;
      bit busy_lost = 1'b0;
      int nv = 0;
      do_arm(1'b0, 2, 0);
      while (done !== 1'b1 && nv < 40) begin
         arm  = (nv == 0) || (nv == 4);
         ring = 1'b1;
         skip = '0;
         sample(nv, 1'b1);
         arm  = 1'b0;
         if (done !== 1'b1 && busy !== 1'b1) busy_lost = 1'b1;
         nv++;
      end
      n_cmp++;
      if (nv != 10 || busy_lost || count !== 4'd8) begin
         n_bad++;
         $display("FAIL arm_ignored: valid_samples=%0d busy_lost=%b count=%0d required 10/0/8",
                  nv, busy_lost, count);
      end
      issue_read(0, ent(2));
      tick();
      rd_en = 1'b0;
      n_cmp++;
      e = sb.pop_front();
      if (rd_valid !== 1'b1 || rd_data !== e) begin
         n_bad++;
         $display("FAIL arm_ignored_read0: rd_valid=%b rd_data=%h required 1/%h", rd_valid, rd_data, e);
      end
      do_arm(1'b0, 0, 0);
      n_cmp++;
      if ({busy, done, count} !== {1'b1, 1'b0, 4'd0}) begin
         n_bad++;
         $display("FAIL rearm_done: busy=%b done=%b count=%0d required 1/0/0", busy, done, count);
      end
   endtask

   task automatic test_reset_mid();
      for (int i = 0; i < 4; i++) sample(40 + i, 1'b1);
      n_cmp++;
      if (count !== 4'd4 || busy !== 1'b1) begin
         n_bad++;
         $display("FAIL mid_capture: count=%0d busy=%b required 4/1", count, busy);
      end
      rst = 1'b0; rd_en = 1'b1; rd_addr = '0; in_valid = 1'b1;
      tick();
      n_cmp++;
      if ({busy, done, rd_valid, count, rd_data} !== '0) begin
         n_bad++;
         $display("FAIL reset_mid: busy=%b done=%b rd_valid=%b count=%0d rd_data=%h required all 0",
                  busy, done, rd_valid, count, rd_data);
      end
      rst = 1'b1; rd_en = 1'b0; in_valid = 1'b0;
      sample(50, 1'b1);
      n_cmp++;
      if (count !== 4'd0 || busy !== 1'b0) begin
         n_bad++;
         $display("FAIL reset_idle: count=%0d busy=%b required 0/0", count, busy);
      end
   endtask

   initial begin
      test_reset();
      test_oneshot();
      test_skip_decim();
      test_ring_full();
      test_ring_short();
      test_arm_ignore();
      test_reset_mid();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
